axis_m_burst: RTL and testbench
===============================

Name: axis_m_burst

Overview:
- Parametrised AXI-Stream master and successor to the single-word stream master.
- Accepts burst requests (seed word plus beat count) into a request queue and streams each request as one tlast-terminated packet.
- Payload is either a constant seed or a seed that increments per beat.
- Queued requests are sent back-to-back with no idle cycle between packets.
- Sits between control/test logic and any AXI-Stream slave.

Parameters:
- DATA_W, 32: tdata width in bits.
- LEN_W, 8: width of the burst-length field. Packet holds len+1 beats, 1..2^LEN_W.
- QDEPTH, 4: request queue depth. Power of two, at least 2.
- INC_MODE, 1: 1 = tdata increments by 1 each beat (mod 2^DATA_W). 0 = tdata holds the seed for every beat.

Ports:
- aclk, in, 1: clock. All logic is on the rising edge.
- areset, in, 1: asynchronous, active-high reset.
- data, in, DATA_W: seed word for the request, sampled with send.
- len, in, LEN_W: beats minus 1 for the request, sampled with send.
- send, in, 1: request strobe, one request per high cycle.
- q_full, out, 1: request queue holds QDEPTH entries.
- q_level, out, $clog2(QDEPTH)+1: number of queued requests, excluding the packet in flight.
- overflow, out, 1: sticky flag. A request was dropped because the queue was full.
- tready, in, 1: slave ready.
- tvalid, out, 1: master valid.
- tlast, out, 1: final beat of the packet.
- tdata, out, DATA_W: payload.
- finish, out, 1: one-cycle pulse after each packet's last handshake.

Behaviour:
- Reset (areset high, asynchronous assert): the following all go to 0 immediately and hold while areset is high.
  - tvalid, tlast, tdata, finish, overflow, q_level, q_full.
  - Queue is flushed and the FSM goes to IDLE.
- Reset asserted mid-packet aborts the packet. No finish pulse is issued. No partial state survives.
- Enqueue: at an edge with send=1 and q_level<QDEPTH, {data,len} is written.
  - Full is judged on the registered q_level only. A same-cycle pop does not make room.
  - send=1 with q_level==QDEPTH: request is dropped, overflow is set to 1, and it stays 1 until reset.
- q_level/q_full: registered. On simultaneous push and pop, q_level is unchanged.
- FSM states are IDLE and STREAM.
- IDLE, queue non-empty at an edge:
  - Pop the head entry.
  - tdata <= seed, beat counter <= len, tvalid <= 1, tlast <= (len==0).
  - Go to STREAM.
- Latency: send sampled at edge k gives tvalid high after edge k+1 (queue empty and IDLE beforehand).
- STREAM, tvalid=1 and tready=0: tvalid, tdata and tlast hold stable. No change of any output.
- STREAM, handshake on a non-last beat:
  - Counter decrements.
  - tdata <= tdata+1 if INC_MODE, else unchanged.
  - tlast <= (counter==1).
- STREAM, handshake on the last beat (tlast=1):
  - finish <= 1 for exactly one cycle.
  - If the queue is non-empty at that edge: pop and load the next request as in IDLE. tvalid stays 1 (back-to-back) and the FSM stays in STREAM.
  - Otherwise: tvalid <= 0, tlast <= 0, go to IDLE. tdata holds its last value.
- Increment wraps: 0xFFFF_FFFF followed by 0x0000_0000 at DATA_W=32.
- tvalid never deasserts without a handshake. The master never waits on tready before asserting tvalid.
- Beats per packet are exactly len+1. len=2^LEN_W-1 gives 256 beats at the default.
- send while a packet is streaming simply enqueues. Streaming is unaffected.

Test Plan:
- Single beat: send with data=0xAAAA_BBBB, len=0, tready=1 constantly.
  - tvalid=1 and tlast=1 for one cycle with tdata=0xAAAA_BBBB.
  - finish pulse on the next cycle.
  - q_level returns to 0.
- Stalled increment burst: data=0x1000, len=3, tready toggled 0,1,0,0,1,1,0,1.
  - Exactly 4 handshakes carrying 0x1000..0x1003.
  - tlast only on 0x1003.
  - tdata stable in every stall cycle.
  - One finish pulse.
- Back-to-back: two sends on consecutive cycles (0xCCCC_DDDD len=1; 0x10 len=0), tready=1.
  - 3 consecutive valid beats: 0xCCCC_DDDD, 0xCCCC_DDDE(tlast), 0x10(tlast).
  - No tvalid gap.
  - Two finish pulses.
- Overflow: tready=0 and 6 sends with QDEPTH=4.
  - First request is popped into flight, next 4 are queued (q_full=1), 6th is dropped.
  - overflow=1 and it persists after the queue drains.
- Reset mid-packet: len=7, assert areset after the 3rd handshake.
  - tvalid, tlast, tdata, q_level and overflow are 0 immediately.
  - No finish pulse.
  - A new send after release streams from its own seed.
- INC_MODE=0 with wrap check: INC_MODE=0, data=0x5, len=2 gives 3 beats all 0x5.
  - Then with INC_MODE=1, data=0xFFFF_FFFF, len=1, the beats are 0xFFFF_FFFF and 0x0.

Source files
------------

// File: rtl/axis_m_burst.sv
// -----------------------------------------------------------------------------
// axis_m_burst
//   AXI-Stream burst master. Requests ({seed, len}) are pushed into a small
//   FIFO and each is streamed as one tlast-terminated packet of len+1 beats.
//   The payload is the seed on every beat (INC_MODE=0) or a seed that
//   increments by one per beat (INC_MODE=1). Queued requests follow one
//   another back-to-back with no idle cycle between packets.
//
// Ports
//   aclk      : clock, rising edge
//   areset    : asynchronous reset, active high
//   data      : seed word of a request, sampled with send
//   len       : beats minus one of a request, sampled with send
//   send      : request strobe, one request per high cycle
//   q_full    : request queue holds QDEPTH entries
//   q_level   : queued requests, not counting the packet in flight
//   overflow  : sticky, a request was dropped because the queue was full
//   tready    : slave ready
//   tvalid    : master valid
//   tlast     : final beat of the packet
//   tdata     : payload
//   finish    : one-cycle pulse after each packet's last handshake
// -----------------------------------------------------------------------------
module axis_m_burst #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int QDEPTH   = 4,
  parameter int INC_MODE = 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [DATA_W-1:0]          data,
  input  logic [LEN_W-1:0]           len,
  input  logic                       send,
  output logic                       q_full,
  output logic [$clog2(QDEPTH):0]    q_level,
  output logic                       overflow,
  input  logic                       tready,
  output logic                       tvalid,
  output logic                       tlast,
  output logic [DATA_W-1:0]          tdata,
  output logic                       finish
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int LVW = AW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [LEN_W-1:0]  q_len  [QDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVW-1:0]    level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Fullness uses the registered level only, so a pop in the same cycle
  // never makes room for a push.
  assign full  = (level == LVW'(QDEPTH));
  assign empty = (level == '0);
  assign push  = send && !full;

  // NOTE: storage is not reset; entries are only read once level says they
  // were written, so clearing them would add reset fanout for no benefit.
  always_ff @(posedge aclk) begin
    if (push) begin
      q_data[wr_ptr] <= data;
      q_len[wr_ptr]  <= len;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVW'(1);
        2'b01:   level <= level - LVW'(1);
        default: level <= level;
      endcase
      if (send && full) overflow <= 1'b1;
    end
  end

  assign q_level = level;
  assign q_full  = full;

  // ---------------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic              valid_nxt;
  logic              last_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              finish_nxt;
  logic              load;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      cnt    <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tdata  <= '0;
      finish <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tvalid <= valid_nxt;
      tlast  <= last_nxt;
      tdata  <= data_nxt;
      finish <= finish_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    valid_nxt  = tvalid;
    last_nxt   = tlast;
    data_nxt   = tdata;
    finish_nxt = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      STREAM: begin
        if (tvalid && tready) begin
          if (tlast) begin
            finish_nxt = 1'b1;
            if (!empty) begin
              // Back-to-back: next packet starts without dropping tvalid.
              load = 1'b1;
            end else begin
              valid_nxt = 1'b0;
              last_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt  = cnt - LEN_W'(1);
            last_nxt = (cnt == LEN_W'(1));
            if (INC_MODE != 0) data_nxt = tdata + DATA_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      data_nxt  = q_data[rd_ptr];
      cnt_nxt   = q_len[rd_ptr];
      valid_nxt = 1'b1;
      last_nxt  = (q_len[rd_ptr] == '0);
      state_nxt = STREAM;
    end
  end

endmodule

// File: tb/tb_axis_m_burst.sv
// -----------------------------------------------------------------------------
// tb_axis_m_burst
//   Self-checking bench for axis_m_burst. A table of hand-derived vectors
//   covers the basic packets, hand-written sequences cover overflow, reset
//   mid-packet, wrap and constant-payload mode, and a random phase compares
//   every cycle against a transaction-level model built from queues.
// -----------------------------------------------------------------------------
module tb_axis_m_burst;

  localparam int QDEPTH = 4;
  localparam int LVW    = $clog2(QDEPTH) + 1;

  logic            aclk = 1'b0;
  logic            areset;
  logic [31:0]     data;
  logic [7:0]      len;
  logic            send;
  logic            tready;
  logic            q_full;
  logic [LVW-1:0]  q_level;
  logic            overflow;
  logic            tvalid;
  logic            tlast;
  logic [31:0]     tdata;
  logic            finish;

  // Second instance in constant-payload mode
  logic [31:0]     data_c;
  logic [7:0]      len_c;
  logic            send_c;
  logic            tready_c;
  logic            q_full_c;
  logic [LVW-1:0]  q_level_c;
  logic            overflow_c;
  logic            tvalid_c;
  logic            tlast_c;
  logic [31:0]     tdata_c;
  logic            finish_c;

  always #5 aclk = ~aclk;

  axis_m_burst #(.DATA_W(32), .LEN_W(8), .QDEPTH(QDEPTH), .INC_MODE(1)) u_dut (
    .aclk(aclk), .areset(areset), .data(data), .len(len), .send(send),
    .q_full(q_full), .q_level(q_level), .overflow(overflow), .tready(tready),
    .tvalid(tvalid), .tlast(tlast), .tdata(tdata), .finish(finish)
  );

  axis_m_burst #(.DATA_W(32), .LEN_W(8), .QDEPTH(QDEPTH), .INC_MODE(0)) u_dut_c (
    .aclk(aclk), .areset(areset), .data(data_c), .len(len_c), .send(send_c),
    .q_full(q_full_c), .q_level(q_level_c), .overflow(overflow_c), .tready(tready_c),
    .tvalid(tvalid_c), .tlast(tlast_c), .tdata(tdata_c), .finish(finish_c)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {logic [31:0] d; logic [7:0] l;} req_t;
  typedef struct packed {logic [31:0] d; logic last;} beat_t;

  req_t        pend_q[$];
  beat_t       beat_q[$];
  logic        m_fin;
  logic        m_ovf;
  logic [31:0] m_last_data;

  task automatic model_reset();
    pend_q.delete();
    beat_q.delete();
    m_fin       = 1'b0;
    m_ovf       = 1'b0;
    m_last_data = '0;
  endtask

  // Applies one rising edge using the inputs the bench is driving.
  task automatic model_edge();
    int    pre_size;
    bit    hs, last_hs, start;
    req_t  r;
    beat_t b;
    pre_size = pend_q.size();
    hs       = (beat_q.size() > 0) && tready;
    last_hs  = hs && beat_q[0].last;
    start    = ((beat_q.size() == 0) || last_hs) && (pre_size > 0);
    if (hs) begin
      m_last_data = beat_q[0].d;
      void'(beat_q.pop_front());
    end
    m_fin = last_hs;
    if (start) begin
      r = pend_q.pop_front();
      for (int i = 0; i <= int'(r.l); i++) begin
        b.d    = r.d + 32'(i);
        b.last = (i == int'(r.l));
        beat_q.push_back(b);
      end
    end
    if (send) begin
      if (pre_size < QDEPTH) begin
        r.d = data;
        r.l = len;
        pend_q.push_back(r);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic        e_valid, e_last;
    logic [31:0] e_data;
    if (beat_q.size() > 0) begin
      e_valid = 1'b1;
      e_last  = beat_q[0].last;
      e_data  = beat_q[0].d;
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_data  = m_last_data;
    end
    check({tag, " tvalid"},   tvalid,   e_valid);
    check({tag, " tlast"},    tlast,    e_last);
    check({tag, " tdata"},    tdata,    e_data);
    check({tag, " finish"},   finish,   m_fin);
    check({tag, " q_level"},  q_level,  64'(pend_q.size()));
    check({tag, " q_full"},   q_full,   pend_q.size() == QDEPTH);
    check({tag, " overflow"}, overflow, m_ovf);
  endtask

  // Called at a falling edge: drive, take one rising edge, return at the
  // next falling edge where outputs are sampled.
  task automatic step(input logic s, input logic [31:0] d, input logic [7:0] l,
                      input logic r);
    send   = s;
    data   = d;
    len    = l;
    tready = r;
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tvalid"},   tvalid,   1'b0);
    check({tag, " tlast"},    tlast,    1'b0);
    check({tag, " tdata"},    tdata,    32'h0);
    check({tag, " finish"},   finish,   1'b0);
    check({tag, " q_level"},  q_level,  '0);
    check({tag, " q_full"},   q_full,   1'b0);
    check({tag, " overflow"}, overflow, 1'b0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    send   = 1'b0;
    tready = 1'b0;
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    areset = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: single beat, stalled increment burst, back-to-back packets
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        s;
    logic [31:0] d;
    logic [7:0]  l;
    logic        r;
    logic        ev;
    logic        el;
    logic [31:0] ed;
    logic        ef;
    logic [2:0]  eq;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  localparam logic [31:0] A = 32'hAAAA_BBBB;
  localparam logic [31:0] C = 32'hCCCC_DDDD;
  localparam logic [31:0] Z = 32'h0;

  initial begin
    // watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fin_cnt;
    int nbeats;
    int guard;

    //            s     d             l     r     ev    el    ed            ef    eq
    vecs[0]  = '{1'b1, A,            8'd0, 1'b1, 1'b0, 1'b0, Z,            1'b0, 3'd1};
    vecs[1]  = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b1, A,            1'b0, 3'd0};
    vecs[2]  = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, A,            1'b1, 3'd0};
    vecs[3]  = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, A,            1'b0, 3'd0};
    vecs[4]  = '{1'b1, 32'h1000,     8'd3, 1'b0, 1'b0, 1'b0, A,            1'b0, 3'd1};
    vecs[5]  = '{1'b0, Z,            8'd0, 1'b0, 1'b1, 1'b0, 32'h1000,     1'b0, 3'd0};
    vecs[6]  = '{1'b0, Z,            8'd0, 1'b0, 1'b1, 1'b0, 32'h1000,     1'b0, 3'd0};
    vecs[7]  = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b0, 32'h1001,     1'b0, 3'd0};
    vecs[8]  = '{1'b0, Z,            8'd0, 1'b0, 1'b1, 1'b0, 32'h1001,     1'b0, 3'd0};
    vecs[9]  = '{1'b0, Z,            8'd0, 1'b0, 1'b1, 1'b0, 32'h1001,     1'b0, 3'd0};
    vecs[10] = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b0, 32'h1002,     1'b0, 3'd0};
    vecs[11] = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b1, 32'h1003,     1'b0, 3'd0};
    vecs[12] = '{1'b0, Z,            8'd0, 1'b0, 1'b1, 1'b1, 32'h1003,     1'b0, 3'd0};
    vecs[13] = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, 32'h1003,     1'b1, 3'd0};
    vecs[14] = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, 32'h1003,     1'b0, 3'd0};
    vecs[15] = '{1'b1, C,            8'd1, 1'b1, 1'b0, 1'b0, 32'h1003,     1'b0, 3'd1};
    vecs[16] = '{1'b1, 32'h10,       8'd0, 1'b1, 1'b1, 1'b0, C,            1'b0, 3'd1};
    vecs[17] = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b1, 32'hCCCC_DDDE, 1'b0, 3'd1};
    vecs[18] = '{1'b0, Z,            8'd0, 1'b1, 1'b1, 1'b1, 32'h10,       1'b1, 3'd0};
    vecs[19] = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, 32'h10,       1'b1, 3'd0};
    vecs[20] = '{1'b0, Z,            8'd0, 1'b1, 1'b0, 1'b0, 32'h10,       1'b0, 3'd0};

    areset   = 1'b1;
    send     = 1'b0;
    data     = '0;
    len      = '0;
    tready   = 1'b0;
    send_c   = 1'b0;
    data_c   = '0;
    len_c    = '0;
    tready_c = 1'b0;
    model_reset();

    // Reset state
    @(negedge aclk);
    do_reset();

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d tvalid", i),  tvalid,  vecs[i].ev);
      check($sformatf("vec%0d tlast", i),   tlast,   vecs[i].el);
      check($sformatf("vec%0d tdata", i),   tdata,   vecs[i].ed);
      check($sformatf("vec%0d finish", i),  finish,  vecs[i].ef);
      check($sformatf("vec%0d q_level", i), q_level, 64'(vecs[i].eq));
    end

    // Increment wrap
    step(1'b1, 32'hFFFF_FFFF, 8'd1, 1'b1);
    step(1'b0, Z, 8'd0, 1'b1);
    check("wrap first tdata", tdata, 32'hFFFF_FFFF);
    check("wrap first tlast", tlast, 1'b0);
    step(1'b0, Z, 8'd0, 1'b1);
    check("wrap second tdata", tdata, 32'h0);
    check("wrap second tlast", tlast, 1'b1);
    step(1'b0, Z, 8'd0, 1'b1);
    check("wrap finish", finish, 1'b1);
    check_model("wrap");

    // Overflow: tready low, six sends into a four-deep queue
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h100 + 32'(i), 8'd0, 1'b0);
      check_model($sformatf("ovf send%0d", i));
      if (i == 4) begin
        check("ovf q_full after 5 sends", q_full, 1'b1);
        check("ovf clear after 5 sends", overflow, 1'b0);
      end
    end
    check("ovf flag after 6 sends", overflow, 1'b1);
    check("ovf q_level after 6 sends", q_level, 64'(4));
    guard = 0;
    while ((tvalid || q_level != 0) && guard < 40) begin
      step(1'b0, Z, 8'd0, 1'b1);
      check_model("ovf drain");
      guard++;
    end
    check("ovf drain bound", guard < 40, 1'b1);
    check("ovf sticky after drain", overflow, 1'b1);
    check("ovf q_level after drain", q_level, 64'(0));

    // Reset mid-packet after the third handshake
    step(1'b1, 32'h2000, 8'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, Z, 8'd0, 1'b1);
      check_model("midrst stream");
    end
    check("midrst tdata before reset", tdata, 32'h2003);
    areset = 1'b1;
    #1;
    check_all_zero("midrst async");
    model_reset();
    repeat (2) begin
      @(negedge aclk);
      check("midrst finish held", finish, 1'b0);
    end
    areset = 1'b0;
    step(1'b1, 32'h3000, 8'd1, 1'b1);
    check_model("midrst resend");
    step(1'b0, Z, 8'd0, 1'b1);
    check("midrst new seed", tdata, 32'h3000);
    check_model("midrst new beat0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, Z, 8'd0, 1'b1);
      check_model("midrst new tail");
    end

    // Constant-payload instance: three beats all carrying the seed
    send_c   = 1'b1;
    data_c   = 32'h5;
    len_c    = 8'd2;
    tready_c = 1'b1;
    @(negedge aclk);
    send_c  = 1'b0;
    fin_cnt = 0;
    nbeats  = 0;
    for (int i = 0; i < 8; i++) begin
      if (tvalid_c) begin
        check($sformatf("inc0 beat%0d tdata", nbeats), tdata_c, 32'h5);
        check($sformatf("inc0 beat%0d tlast", nbeats), tlast_c, nbeats == 2);
        nbeats++;
      end
      if (finish_c) fin_cnt++;
      @(negedge aclk);
    end
    check("inc0 beat count", 64'(nbeats), 64'(3));
    check("inc0 finish count", 64'(fin_cnt), 64'(1));
    check("inc0 q_level", q_level_c, '0);
    check("inc0 q_full", q_full_c, 1'b0);
    check("inc0 overflow", overflow_c, 1'b0);

    // Random phase, opening with a maximum-length packet
    do_reset();
    step(1'b1, $urandom, 8'd255, 1'b1);
    check_model("rand maxlen");
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 9) < 3, $urandom, 8'($urandom_range(0, 4)),
           $urandom_range(0, 3) != 0);
      check_model($sformatf("rand cyc%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
